// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle Hack CPU sequencer with req/ack instruction and data ports
module cpu_sequencer #(
    parameter int                  DATA_WIDTH = 16,
    parameter int                  PC_WIDTH   = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_imem_req,
    output logic [PC_WIDTH-1:0]   o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic                  i_dmem_ack,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic [DATA_WIDTH-1:0] o_alu_x,
    output logic [DATA_WIDTH-1:0] o_alu_y,
    output logic [5:0]            o_alu_comp,
    input  logic [DATA_WIDTH-1:0] i_alu_o,
    input  logic                  i_alu_zr,
    input  logic                  i_alu_ng,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [DATA_WIDTH-1:0] o_a_reg,
    output logic [DATA_WIDTH-1:0] o_d_reg,
    output logic                  o_trap,
    output logic [31:0]           o_instret
);

    typedef enum logic [2:0] {BOOT, FETCH, MREAD, EXEC, MWRITE, TRAP} state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] a, d, ir, m_lat, wdata, waddr;
    logic [31:0]           instret;
    logic                  jump;
    logic [PC_WIDTH-1:0]   pc_inc;

    assign jump   = (ir[2] & i_alu_ng) | (ir[1] & i_alu_zr) | (ir[0] & ~i_alu_ng & ~i_alu_zr);
    assign pc_inc = pc + PC_WIDTH'(1);

    // Requests are decoded straight from the state register so reset drops them asynchronously.
    assign o_imem_req   = (state == FETCH);
    assign o_imem_addr  = pc;
    assign o_dmem_req   = (state == MREAD) || (state == MWRITE);
    assign o_dmem_we    = (state == MWRITE);
    assign o_dmem_addr  = (state == MWRITE) ? waddr : a;
    assign o_dmem_wdata = wdata;
    assign o_alu_x      = d;
    assign o_alu_y      = ir[12] ? m_lat : a;
    assign o_alu_comp   = ir[11:6];
    assign o_pc         = pc;
    assign o_a_reg      = a;
    assign o_d_reg      = d;
    assign o_trap       = (state == TRAP);
    assign o_instret    = instret;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            a       <= '0;
            d       <= '0;
            ir      <= '0;
            m_lat   <= '0;
            wdata   <= '0;
            waddr   <= '0;
            instret <= '0;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: if (i_imem_ack) begin
                    ir <= i_imem_data;
                    if (!i_imem_data[15])
                        state <= EXEC;
                    else if (i_imem_data[15:13] == 3'b111)
                        state <= i_imem_data[12] ? MREAD : EXEC;
                    else
                        state <= TRAP;
                end
                MREAD: if (i_dmem_ack) begin
                    m_lat <= i_dmem_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!ir[15]) begin
                        a       <= ir;
                        pc      <= pc_inc;
                        state   <= FETCH;
                        instret <= instret + 32'd1;
                    end else begin
                        if (ir[5]) a <= i_alu_o;
                        if (ir[4]) d <= i_alu_o;
                        if (ir[3]) begin
                            wdata <= i_alu_o;
                            waddr <= a;
                        end
                        // Jump target uses A as it was before this cycle's write.
                        pc <= jump ? a[PC_WIDTH-1:0] : pc_inc;
                        if (ir[3]) begin
                            state <= MWRITE;
                        end else begin
                            state   <= FETCH;
                            instret <= instret + 32'd1;
                        end
                    end
                end
                MWRITE: if (i_dmem_ack) begin
                    state   <= FETCH;
                    instret <= instret + 32'd1;
                end
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - table-driven and directed bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [14:0] imem_addr, pc;
    logic [15:0] imem_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_o, a_reg, d_reg;
    logic [5:0]  alu_comp;
    logic        alu_zr, alu_ng, trap;
    logic [31:0] instret;

    logic [15:0] imem [64];
    logic [15:0] dmem [256];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic        load_en = 1'b1;
    logic [7:0]  preset_addr = 8'd0;
    logic [15:0] preset_val = 16'd0;
    int          wr_count = 0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_data(imem_data),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
        .o_alu_x(alu_x), .o_alu_y(alu_y), .o_alu_comp(alu_comp),
        .i_alu_o(alu_o), .i_alu_zr(alu_zr), .i_alu_ng(alu_ng),
        .o_pc(pc), .o_a_reg(a_reg), .o_d_reg(d_reg), .o_trap(trap), .o_instret(instret)
    );

    assign imem_data  = imem[imem_addr[5:0]];
    assign dmem_rdata = dmem[dmem_addr[7:0]];

    // Hack ALU: zx nx zy ny f no
    logic [15:0] ax, ay, ar;
    always_comb begin
        ax = alu_comp[5] ? 16'd0 : alu_x;
        if (alu_comp[4]) ax = ~ax;
        ay = alu_comp[3] ? 16'd0 : alu_y;
        if (alu_comp[2]) ay = ~ay;
        ar = alu_comp[1] ? ax + ay : ax & ay;
        if (alu_comp[0]) ar = ~ar;
    end
    assign alu_o  = ar;
    assign alu_zr = (ar == 16'd0);
    assign alu_ng = ar[15];

    always @(negedge clk) begin
        if (imem_req) begin
            if (icnt == iwait) begin imem_ack = 1'b1; icnt = 0; end
            else begin imem_ack = 1'b0; icnt++; end
        end else begin imem_ack = 1'b0; icnt = 0; end
        if (dmem_req) begin
            if (dcnt == dwait) begin dmem_ack = 1'b1; dcnt = 0; end
            else begin dmem_ack = 1'b0; dcnt++; end
        end else begin dmem_ack = 1'b0; dcnt = 0; end
    end

    always @(posedge clk) begin
        if (!rst_n && load_en) begin
            for (int i = 0; i < 256; i++) dmem[i] = 16'd0;
            dmem[preset_addr] = preset_val;
            wr_count = 0;
        end else if (rst_n && dmem_req && dmem_we && dmem_ack) begin
            dmem[dmem_addr[7:0]] = dmem_wdata;
            wr_count++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_and_reset(input logic [3:0][15:0] prog, input logic [7:0] paddr,
                                  input logic [15:0] pval);
        rst_n = 1'b0;
        load_en = 1'b1;
        preset_addr = paddr;
        preset_val = pval;
        for (int i = 0; i < 64; i++) imem[i] = 16'd0;
        for (int i = 0; i < 4; i++) imem[i] = prog[i];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_en = 1'b0;
    endtask

    task automatic wait_instret(input logic [31:0] target, output int cyc);
        cyc = 0;
        while (instret != target && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("instret_reached", instret, target);
    endtask

    typedef struct {
        string              name;
        logic [3:0][15:0]   prog;
        logic [31:0]        n;
        logic [15:0]        a, d;
        logic [14:0]        pc;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [15:0] p0, p1, p2, p3,
                                input logic [31:0] n, input logic [15:0] a, d, input logic [14:0] p);
        vec_t v;
        v.name = nm;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
        v.n = n; v.a = a; v.d = d; v.pc = p;
        return v;
    endfunction

    vec_t vecs [7];
    int   cyc, wcyc, bad, reqs;

    initial begin
        vecs[0] = mk("at5_d_eq_a",   16'h0005, 16'hEC10, 16'h0000, 16'h0000, 2, 16'h0005, 16'h0005, 15'd2);
        vecs[1] = mk("jmp_uncond",   16'h0008, 16'hEA87, 16'h0000, 16'h0000, 2, 16'h0008, 16'h0000, 15'd8);
        vecs[2] = mk("jgt_not_taken",16'h0008, 16'hEE90, 16'hE301, 16'h0000, 3, 16'h0008, 16'hFFFF, 15'd3);
        vecs[3] = mk("jgt_taken",    16'h0003, 16'hEC10, 16'h0008, 16'hE301, 4, 16'h0008, 16'h0003, 15'd8);
        vecs[4] = mk("a_inst_max",   16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1, 16'h7FFF, 16'h0000, 15'd1);
        vecs[5] = mk("jeq_zero",     16'h0009, 16'hE302, 16'h0000, 16'h0000, 2, 16'h0009, 16'h0000, 15'd9);
        vecs[6] = mk("ad_jmp_old_a", 16'h000C, 16'hEDF7, 16'h0000, 16'h0000, 2, 16'h000D, 16'h000D, 15'd12);

        // Reset state and first fetch timing
        load_and_reset({16'h0, 16'h0, 16'hEC10, 16'h0005}, 8'd0, 16'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_pc", {17'd0, pc}, 32'd0);
        check("rst_a", {16'd0, a_reg}, 32'd0);
        check("rst_instret", instret, 32'd0);
        rst_n = 1'b1;
        #1 check("boot_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_fetch_req", {31'd0, imem_req}, 32'd1);

        foreach (vecs[i]) begin
            load_and_reset(vecs[i].prog, 8'd0, 16'd0);
            wait_instret(vecs[i].n, cyc);
            check({vecs[i].name, "_a"}, {16'd0, a_reg}, {16'd0, vecs[i].a});
            check({vecs[i].name, "_d"}, {16'd0, d_reg}, {16'd0, vecs[i].d});
            check({vecs[i].name, "_pc"}, {17'd0, pc}, {17'd0, vecs[i].pc});
        end

        // PC increment wraps at 2^PC_WIDTH
        load_and_reset({16'h0, 16'h0, 16'hEA87, 16'h7FFF}, 8'd0, 16'd0);
        imem[63] = 16'h0002;
        wait_instret(3, cyc);
        check("wrap_pc", {17'd0, pc}, 32'd0);
        check("wrap_a", {16'd0, a_reg}, 32'd2);

        // M=D with a 3-cycle delayed write ack
        load_and_reset({16'hE308, 16'h0064, 16'hEC10, 16'h0007}, 8'd0, 16'd0);
        dwait = 3;
        wait_instret(3, cyc);
        cyc = 0; wcyc = 0; bad = 0;
        while (instret == 32'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (dmem_req) begin
                wcyc++;
                if (dmem_addr != 16'd100 || dmem_wdata != 16'd7 || !dmem_we) bad++;
            end
        end
        check("mw_latency", cyc, 32'd6);
        check("mw_req_cycles", wcyc, 32'd4);
        check("mw_stable", bad, 32'd0);
        check("mw_count", wr_count, 32'd1);
        check("mw_data", {16'd0, dmem[100]}, 32'd7);
        dwait = 0;

        // M=M+1 with zero-wait memories
        load_and_reset({16'h0, 16'h0, 16'hFDC8, 16'h0064}, 8'd100, 16'd41);
        wait_instret(1, cyc);
        wait_instret(2, cyc);
        check("mrw_latency", cyc, 32'd4);
        check("mrw_data", {16'd0, dmem[100]}, 32'd42);
        check("mrw_count", wr_count, 32'd1);

        // Illegal encoding traps and freezes state
        load_and_reset({16'h0, 16'h0, 16'h8000, 16'h0005}, 8'd0, 16'd0);
        wait_instret(1, cyc);
        cyc = 0;
        while (!trap && cyc < 10) begin @(negedge clk); cyc++; end
        check("trap_set", {31'd0, trap}, 32'd1);
        reqs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req || dmem_req) reqs++;
        end
        check("trap_no_req", reqs, 32'd0);
        check("trap_a", {16'd0, a_reg}, 32'd5);
        check("trap_d", {16'd0, d_reg}, 32'd0);
        check("trap_pc", {17'd0, pc}, 32'd1);
        check("trap_instret", instret, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("trap_cleared", {31'd0, trap}, 32'd0);
        check("trap_rst_pc", {17'd0, pc}, 32'd0);

        // Reset during a pending write
        load_and_reset({16'h0, 16'h0, 16'hEA88, 16'h0064}, 8'd100, 16'h1234);
        dwait = 5;
        cyc = 0;
        while (!dmem_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("mwr_req_seen", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mwr_req_drop", {31'd0, dmem_req}, 32'd0);
        repeat (3) @(negedge clk);
        check("mwr_no_commit", {16'd0, dmem[100]}, 32'h1234);
        check("mwr_no_count", wr_count, 32'd0);
        rst_n = 1'b1;
        dwait = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
